fetch_stage: RTL

- Instruction-fetch stage of the pipelined RV32I core. Owns the program counter and drives the address of the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Handles decode-side stalls and EX-side redirects (taken branch/jump) by inserting bubbles, and flags misaligned redirect targets.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and fills the IF/ID register.
// Define FETCH_PERF_CNT_EN to enable the fetch and redirect counters; otherwise both counter ports read zero.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] pc_id_o,
    output logic [31:0] pc_plus4_id_o,
    output logic [31:0] instr_id_o,
    output logic        valid_id_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] fetch_count_o,
    output logic [31:0] redirect_count_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic        valid_id_q, valid_id_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        advance;

    // A redirect squashes the fetch in flight and wins over a stall.
    assign advance = ~redirect_i & ~stall_i;

    always_comb begin
        pc_d          = pc_q;
        pc_id_d       = pc_id_q;
        pc_plus4_id_d = pc_plus4_id_q;
        instr_id_d    = instr_id_q;
        valid_id_d    = valid_id_q;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        if (redirect_i) begin
            pc_d       = {redirect_target_i[31:2], 2'b00};
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
            if ((redirect_target_i[1:0] != 2'b00) && !fault_q) begin
                fault_d    = 1'b1;
                fault_pc_d = redirect_target_i;
            end
        end else if (advance) begin
            pc_d          = pc_q + 32'd4;
            pc_id_d       = pc_q;
            pc_plus4_id_d = pc_q + 32'd4;
            instr_id_d    = imem_rdata_i;
            valid_id_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            pc_id_q       <= 32'h0;
            pc_plus4_id_q <= 32'h4;
            instr_id_q    <= NOP_INSTR;
            valid_id_q    <= 1'b0;
            fault_q       <= 1'b0;
            fault_pc_q    <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            pc_id_q       <= pc_id_d;
            pc_plus4_id_q <= pc_plus4_id_d;
            instr_id_q    <= instr_id_d;
            valid_id_q    <= valid_id_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        fetch_count_d    = fetch_count_q;
        redirect_count_d = redirect_count_q;
        if (redirect_i) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end else if (advance) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q    <= 32'h0;
            redirect_count_q <= 32'h0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count_o    = fetch_count_q;
    assign redirect_count_o = redirect_count_q;
`else
    assign fetch_count_o    = 32'h0;
    assign redirect_count_o = 32'h0;
`endif

    assign imem_addr_o   = pc_q;
    assign pc_id_o       = pc_id_q;
    assign pc_plus4_id_o = pc_plus4_id_q;
    assign instr_id_o    = instr_id_q;
    assign valid_id_o    = valid_id_q;
    assign fault_o       = fault_q;
    assign fault_pc_o    = fault_pc_q;

endmodule
